// File: rtl/npc_bp.sv
// npc_bp: fetch PC register with direct-mapped BTB / 2-bit counter prediction,
// EX-stage branch resolution, misprediction repair and event counters.
module npc_bp #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     BTB_IDX_W = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h1c000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_stall,
  output logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [PC_W-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic [1:0]      ex_npc_op,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_rj_pc,
  input  logic [PC_W-1:0] ex_offset,
  input  logic            ex_branch,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            flush,
  output logic            jump_taken,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W   = PC_W - BTB_IDX_W - 2;

  typedef enum logic [1:0] {
    OP_PC4  = 2'd0,
    OP_JIRL = 2'd1,
    OP_BL   = 2'd2,
    OP_BX   = 2'd3
  } npc_op_e;

  npc_op_e ex_op;
  assign ex_op = npc_op_e'(ex_npc_op);

  logic [PC_W-1:0]      if_pc_q, if_pc_d;
  logic                 valid_q [ENTRIES];
  logic                 valid_d [ENTRIES];
  logic [TAG_W-1:0]     tag_q   [ENTRIES];
  logic [TAG_W-1:0]     tag_d   [ENTRIES];
  logic [PC_W-1:0]      tgt_q   [ENTRIES];
  logic [PC_W-1:0]      tgt_d   [ENTRIES];
  logic [1:0]           cnt_q   [ENTRIES];
  logic [1:0]           cnt_d   [ENTRIES];
  logic [31:0]          br_cnt_q, br_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;

  logic [BTB_IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  logic                 if_hit, ex_hit;
  logic                 ex_taken;
  logic [PC_W-1:0]      ex_target, ex_btb_tgt;

  assign if_pc       = if_pc_q;
  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign ex_idx      = ex_pc[BTB_IDX_W+1:2];
  assign ex_tag      = ex_pc[PC_W-1:BTB_IDX_W+2];

  // BTB lookup for the current fetch PC (sees pre-update contents)
  always_comb begin
    if_idx         = if_pc_q[BTB_IDX_W+1:2];
    if_tag         = if_pc_q[PC_W-1:BTB_IDX_W+2];
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_pred_taken  = if_hit && cnt_q[if_idx][1];
    if_pred_target = if_pred_taken ? tgt_q[if_idx] : if_pc_q + PC_W'(4);
  end

  // Resolve the EX instruction and detect mispredictions
  always_comb begin
    ex_taken   = 1'b0;
    ex_target  = ex_pc + PC_W'(4);
    ex_btb_tgt = ex_pc + ex_offset;
    if (ex_valid) begin
      unique case (ex_op)
        OP_PC4:  ex_taken = 1'b0;
        OP_JIRL: begin
          ex_taken   = 1'b1;
          ex_target  = ex_rj_pc + ex_offset;
          ex_btb_tgt = ex_rj_pc + ex_offset;
        end
        OP_BL: begin
          ex_taken  = 1'b1;
          ex_target = ex_pc + ex_offset;
        end
        OP_BX: begin
          ex_taken = ex_branch;
          if (ex_branch) ex_target = ex_pc + ex_offset;
        end
      endcase
    end
    jump_taken = ex_taken;
    flush      = ex_valid && ((ex_pred_taken != ex_taken) ||
                              (ex_taken && (ex_pred_target != ex_target)));
  end

  // Next fetch PC: redirect beats stall, stall beats prediction
  always_comb begin
    if (flush)         if_pc_d = ex_target;
    else if (if_stall) if_pc_d = if_pc_q;
    else               if_pc_d = if_pred_target;
  end

  // BTB entry update / allocation / alias invalidation from EX
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (ex_valid) begin
      if (ex_op != OP_PC4) begin
        tgt_d[ex_idx] = ex_btb_tgt;
        if (ex_hit) begin
          if (ex_op != OP_BX)                       cnt_d[ex_idx] = 2'b11;
          else if (ex_taken && cnt_q[ex_idx] != 2'b11)  cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
          else if (!ex_taken && cnt_q[ex_idx] != 2'b00) cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
        end else begin
          valid_d[ex_idx] = 1'b1;
          tag_d[ex_idx]   = ex_tag;
          cnt_d[ex_idx]   = ex_taken ? 2'b10 : 2'b01;
        end
      end else if (ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  // Event counters (wrap naturally)
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ex_valid && ex_op != OP_PC4) br_cnt_d = br_cnt_q + 32'd1;
    if (flush)                       mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc_q       <= RESET_PC;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else begin
      if_pc_q       <= if_pc_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_bp.sv
// Bench for npc_bp: directed scenarios then random EX traffic, all checked
// against a behavioural next-PC / BTB model.
module tb_npc_bp;

  localparam logic [31:0] RST = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_stall;
  logic [31:0] if_pc, if_pred_target;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [1:0]  ex_npc_op;
  logic [31:0] ex_pc, ex_rj_pc, ex_offset, ex_pred_target;
  logic        ex_branch, ex_pred_taken;
  logic        flush, jump_taken;
  logic [31:0] br_cnt, mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  npc_bp #(.PC_W(32), .BTB_IDX_W(4), .RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n), .if_stall(if_stall),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_pc(ex_pc), .ex_rj_pc(ex_rj_pc),
    .ex_offset(ex_offset), .ex_branch(ex_branch), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush), .jump_taken(jump_taken),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc, m_br, m_mis;
  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];

  function automatic void m_reset();
    m_pc = RST; m_br = 0; m_mis = 0;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_cnt[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int i = int'(pc[5:2]);
    bit hit = m_v[i] && (m_tag[i] == pc[31:6]);
    tk = hit && (m_cnt[i] >= 2);
    tg = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_resolve(output bit tk, output logic [31:0] tg, output bit fl);
    tk = 0; tg = ex_pc + 32'd4; fl = 0;
    if (ex_valid) begin
      case (ex_npc_op)
        2'd1: begin tk = 1; tg = ex_rj_pc + ex_offset; end
        2'd2: begin tk = 1; tg = ex_pc + ex_offset; end
        2'd3: begin tk = ex_branch; if (tk) tg = ex_pc + ex_offset; end
        default: ;
      endcase
      fl = (ex_pred_taken != tk) || (tk && ex_pred_target != tg);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the model, clock once, advance the model.
  task automatic step();
    bit ptk, rtk, fl, hit;
    logic [31:0] ptg, rtg;
    int i;
    #1;
    m_lookup(m_pc, ptk, ptg);
    m_resolve(rtk, rtg, fl);
    chk("if_pc", if_pc, m_pc);
    chk("if_pred_taken", 32'(if_pred_taken), 32'(ptk));
    chk("if_pred_target", if_pred_target, ptg);
    chk("flush", 32'(flush), 32'(fl));
    chk("jump_taken", 32'(jump_taken), 32'(rtk));
    chk("br_cnt", br_cnt, m_br);
    chk("mispred_cnt", mispred_cnt, m_mis);
    @(posedge clk);
    if (fl) m_pc = rtg;
    else if (!if_stall) m_pc = ptg;
    if (ex_valid) begin
      i   = int'(ex_pc[5:2]);
      hit = m_v[i] && (m_tag[i] == ex_pc[31:6]);
      if (ex_npc_op != 2'd0) begin
        m_br = m_br + 1;
        m_tgt[i] = (ex_npc_op == 2'd1) ? ex_rj_pc + ex_offset : ex_pc + ex_offset;
        if (hit) begin
          if (ex_npc_op != 2'd3) m_cnt[i] = 3;
          else if (rtk)          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          else                   m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end else begin
          m_v[i] = 1; m_tag[i] = ex_pc[31:6]; m_cnt[i] = rtk ? 2 : 1;
        end
      end else if (hit) begin
        m_v[i] = 0;
      end
    end
    if (fl) m_mis = m_mis + 1;
    @(negedge clk);
  endtask

  task automatic set_ex(input bit v, input logic [1:0] op, input logic [31:0] pc,
                        input logic [31:0] rj, input logic [31:0] off, input bit br,
                        input bit ptk, input logic [31:0] ptg);
    ex_valid = v; ex_npc_op = op; ex_pc = pc; ex_rj_pc = rj; ex_offset = off;
    ex_branch = br; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  task automatic idle();
    set_ex(0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    bit ptk;
    logic [31:0] ptg;
    rst_n = 1'b0; if_stall = 1'b0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: free-running sequential fetch
    chk("t1_pc0", if_pc, 32'h1c000000);
    step(); chk("t1_pc1", if_pc, 32'h1c000004);
    step(); chk("t1_pc2", if_pc, 32'h1c000008);
    chk("t1_nopred", 32'(if_pred_taken), 32'd0);

    // 2: stall holds, flush overrides stall
    if_stall = 1'b1;
    repeat (3) step();
    chk("t2_hold", if_pc, 32'h1c000008);
    set_ex(1, 2'd2, 32'h1c000100, 0, 32'h20, 0, 0, 0);
    step(); chk("t2_flush_in_stall", if_pc, 32'h1c000120);
    if_stall = 1'b0;

    // 3: BX taken allocates, then trains down
    set_ex(1, 2'd3, 32'h1c000010, 0, 32'h40, 1, 0, 0);
    step(); chk("t3_redirect", if_pc, 32'h1c000050);
    idle(); step();
    set_ex(1, 2'd1, 32'h1c000300, 32'h1c000010, 32'h0, 0, 0, 0);
    step(); chk("t3_refetch", if_pc, 32'h1c000010);
    chk("t3_pred_taken", 32'(if_pred_taken), 32'd1);
    chk("t3_pred_target", if_pred_target, 32'h1c000050);
    set_ex(1, 2'd3, 32'h1c000010, 0, 32'h40, 0, 1, 32'h1c000050);
    step(); chk("t3_fallthrough", if_pc, 32'h1c000014);
    set_ex(1, 2'd1, 32'h1c000300, 32'h1c000010, 32'h0, 0, 0, 0);
    step(); chk("t3_refetch2", if_pc, 32'h1c000010);
    chk("t3_weak_nopred", 32'(if_pred_taken), 32'd0);

    // 4: JIRL target mismatch
    set_ex(1, 2'd1, 32'h1c000400, 32'h1c001000, 32'h8, 0, 1, 32'h1c000900);
    step(); chk("t4_jirl", if_pc, 32'h1c001008);

    // 5: PC4 alias of a BTB entry predicted taken
    set_ex(1, 2'd0, 32'h1c000010, 0, 0, 0, 1, 32'h1c000050);
    step(); chk("t5_alias", if_pc, 32'h1c000014);
    idle(); step();

    // 6: mispredict counter wrap
    force dut.mispred_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.mispred_cnt_q;
    m_mis = 32'hFFFFFFFF;
    set_ex(1, 2'd2, 32'h1c000500, 0, 32'h100, 0, 0, 0);
    step(); chk("t6_wrap", mispred_cnt, 32'd0);

    // Random traffic with a mid-run asynchronous reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      if (n == 200) begin
        #2;
        rst_n = 1'b0; idle(); if_stall = 1'b0;
        #1;
        chk("rst_pc", if_pc, RST);
        chk("rst_br", br_cnt, 32'd0);
        chk("rst_mis", mispred_cnt, 32'd0);
        chk("rst_pred", 32'(if_pred_taken), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      pc = 32'h1c000000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 6);
      set_ex($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), pc,
             32'h1c000000 | (32'($urandom_range(0, 255)) << 2),
             (32'($urandom_range(0, 255)) << 2) - 32'd512,
             $urandom_range(0, 1) == 1, 0, 0);
      if ($urandom_range(0, 1) == 1) begin
        m_lookup(pc, ptk, ptg);
        ex_pred_taken = ptk; ex_pred_target = ptg;
      end else begin
        ex_pred_taken  = $urandom_range(0, 1) == 1;
        ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_pc + ex_offset
                                                     : 32'h1c000000 | (32'($urandom_range(0, 63)) << 2);
      end
      if_stall = $urandom_range(0, 4) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
